// File: rtl/moore_sm_if.sv
// Serial bit in, registered run-length state code out.
// Master drives the bit stream; slave is the classifier.
interface moore_sm_if;
  logic       in;
  logic [2:0] out;

  modport master (
    output in,
    input  out
  );

  modport slave (
    input  in,
    output out
  );
endinterface

// File: rtl/moore_sm.sv
// Moore run-length classifier: counts equal consecutive bits,
// saturating at three; the state code is the output.
module moore_sm (
  input  logic        clk,
  input  logic        reset,
  moore_sm_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ONE1  = 3'd1,
    ONE2  = 3'd2,
    ONE3  = 3'd3,
    ZERO1 = 3'd4,
    ZERO2 = 3'd5,
    ZERO3 = 3'd6
  } state_t;

  // Held as a plain vector so code 7 is representable and recoverable.
  logic [2:0] state_q;
  logic [2:0] state_d;

  // Next state from (state, in); code 7 and anything unknown go to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:  state_d = bus.in ? ONE1 : ZERO1;
      ONE1:  state_d = bus.in ? ONE2 : ZERO1;
      ONE2:  state_d = bus.in ? ONE3 : ZERO1;
      ONE3:  state_d = bus.in ? ONE3 : ZERO1;
      ZERO1: state_d = bus.in ? ONE1 : ZERO2;
      ZERO2: state_d = bus.in ? ONE1 : ZERO3;
      ZERO3: state_d = bus.in ? ONE1 : ZERO3;
      default: state_d = IDLE;
    endcase
  end

  // State register; active-low reset forces IDLE without a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign bus.out = state_q;

endmodule

// File: tb/tb_moore_sm.sv
// Directed bench for moore_sm: run-length model checked every cycle
// plus hand-computed literal expectations.
module tb_moore_sm;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   chk_en;

  moore_sm_if sm_if ();

  moore_sm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sm_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: last bit value and run length (0 = no history / IDLE).
  bit m_val = 1'b0;
  int m_cnt = 0;
  bit m_ill = 1'b0;

  function automatic logic [2:0] m_exp();
    if (m_ill) return 3'd7;
    if (m_cnt == 0) return 3'd0;
    if (m_val) return 3'(m_cnt);
    return 3'(m_cnt + 3);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_cnt = 0;
      m_ill = 1'b0;
    end else if (m_ill) begin
      m_cnt = 0;
      m_ill = 1'b0;
    end else if (m_cnt != 0 && sm_if.in == m_val) begin
      if (m_cnt < 3) m_cnt = m_cnt + 1;
    end else begin
      m_val = sm_if.in;
      m_cnt = 1;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (sm_if.out !== m_exp()) begin
        bad++;
        $display("FAIL model t=%0t out=%0d expected=%0d",
                 $time, sm_if.out, m_exp());
      end
    end
  end

  task automatic chk(input string name, input logic [2:0] exp);
    total++;
    if (sm_if.out !== exp) begin
      bad++;
      $display("FAIL %s out=%0d expected=%0d", name, sm_if.out, exp);
    end
  endtask

  // Drive a bit, let one rising edge sample it, end just after negedge.
  task automatic tick(input bit b);
    sm_if.in = b;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    chk_en = 1'b0;
    reset = 1'b0;
    sm_if.in = 1'b0;
    #1;
    chk("reset_before_edge", 3'd0);
    chk_en = 1'b1;

    tick(1'b1); chk("hold0", 3'd0);
    tick(1'b0); chk("hold1", 3'd0);
    tick(1'b1); chk("hold2", 3'd0);

    reset = 1'b1;
    tick(1'b1); chk("ones1", 3'd1);
    tick(1'b1); chk("ones2", 3'd2);
    tick(1'b1); chk("ones3", 3'd3);
    tick(1'b1); chk("ones_sat", 3'd3);

    tick(1'b0); chk("zeros1", 3'd4);
    tick(1'b0); chk("zeros2", 3'd5);
    tick(1'b0); chk("zeros3", 3'd6);
    tick(1'b0); chk("zeros_sat", 3'd6);
    tick(1'b1); chk("zeros_to_one", 3'd1);

    reset = 1'b0;
    #1;
    chk("reset_pulse", 3'd0);
    reset = 1'b1;
    tick(1'b1); chk("alt0", 3'd1);
    tick(1'b0); chk("alt1", 3'd4);
    tick(1'b1); chk("alt2", 3'd1);
    tick(1'b0); chk("alt3", 3'd4);

    tick(1'b0); chk("zero2_pre", 3'd5);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset", 3'd0);
    tick(1'b1); chk("async_hold0", 3'd0);
    tick(1'b0); chk("async_hold1", 3'd0);
    reset = 1'b1;
    tick(1'b0); chk("after_release", 3'd4);

    force dut.state_q = 3'd7;
    m_ill = 1'b1;
    #1;
    release dut.state_q;
    #1;
    chk("forced7_in0", 3'd7);
    tick(1'b0); chk("recover_in0", 3'd0);
    tick(1'b1); chk("from_idle", 3'd1);

    force dut.state_q = 3'd7;
    m_ill = 1'b1;
    #1;
    release dut.state_q;
    #1;
    chk("forced7_in1", 3'd7);
    tick(1'b1); chk("recover_in1", 3'd0);
    tick(1'b1); chk("post_recover", 3'd1);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
